// File: rtl/mult_secuencial_8b.sv
// ---------------------------------------------------------------------------
// mult_secuencial_8b
// Sequential 8x8 unsigned shift-and-add multiplier. One partial sum is formed
// per clock through a single adder8B instance; eight iterations are needed
// for each product.
//
// Ports:
//   clk       in   system clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   inicio    in   start request (accepted in REPOSO or FIN)
//   a         in   [7:0]  unsigned multiplicand, captured on start
//   b         in   [7:0]  unsigned multiplier, captured on start
//   producto  out  [15:0] registered product, updated on entry to FIN
//   listo     out  one-cycle pulse: producto newly valid
//   ocupado   out  high while iterating (state CALCULO)
//
// Also contains adder8B, the 8-bit ripple adder with carry in/out used for
// every partial sum.
// ---------------------------------------------------------------------------

module adder8B (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       entAcarreo,
    output logic [7:0] suma,
    output logic       salAcarreo
);

    // 9-bit sum; the carry out forms the top bit
    assign {salAcarreo, suma} = {1'b0, a} + {1'b0, b} + {8'd0, entAcarreo};

endmodule

module mult_secuencial_8b (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        inicio,
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic [15:0] producto,
    output logic        listo,
    output logic        ocupado
);

    typedef enum logic [1:0] {
        REPOSO  = 2'd0,
        CALCULO = 2'd1,
        FIN     = 2'd2
    } state_t;

    state_t      state_r;
    state_t      state_s;

    logic [7:0]  mcand_r;
    logic [7:0]  mplier_r;
    logic [7:0]  acc_r;
    logic [2:0]  cnt_r;
    logic [15:0] producto_r;
    logic        listo_r;
    logic        ocupado_r;

    logic        load_s;
    logic        step_s;
    logic        last_s;
    logic [7:0]  addend_s;
    logic [7:0]  sum_s;
    logic        carry_s;
    logic [7:0]  acc_shift_s;
    logic [7:0]  mplier_shift_s;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= REPOSO;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic; an undefined encoding falls back to REPOSO
    always_comb begin
        state_s = state_r;
        case (state_r)
            REPOSO: begin
                if (inicio) begin
                    state_s = CALCULO;
                end else begin
                    state_s = REPOSO;
                end
            end
            CALCULO: begin
                if (cnt_r == 3'd7) begin
                    state_s = FIN;
                end else begin
                    state_s = CALCULO;
                end
            end
            FIN: begin
                if (inicio) begin
                    state_s = CALCULO;
                end else begin
                    state_s = REPOSO;
                end
            end
            default: begin
                state_s = REPOSO;
            end
        endcase
    end

    // Datapath control strobes and the addend selected by the multiplier LSB
    always_comb begin
        load_s = inicio && ((state_r == REPOSO) || (state_r == FIN));
        step_s = (state_r == CALCULO);
        last_s = step_s && (cnt_r == 3'd7);
        if (mplier_r[0]) begin
            addend_s = mcand_r;
        end else begin
            addend_s = 8'd0;
        end
    end

    adder8B u_adder (
        .a          (acc_r),
        .b          (addend_s),
        .entAcarreo (1'b0),
        .suma       (sum_s),
        .salAcarreo (carry_s)
    );

    // {carry, sum, multiplier} shifted right by one: the bit falling out of
    // the sum becomes the new multiplier MSB, so the low product half
    // accumulates in the multiplier register as its own bits are consumed.
    assign acc_shift_s    = {carry_s, sum_s[7:1]};
    assign mplier_shift_s = {sum_s[0], mplier_r[7:1]};

    // Operand capture, iteration and result load
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_r    <= 8'd0;
            mplier_r   <= 8'd0;
            acc_r      <= 8'd0;
            cnt_r      <= 3'd0;
            producto_r <= 16'd0;
        end else if (load_s) begin
            mcand_r  <= a;
            mplier_r <= b;
            acc_r    <= 8'd0;
            cnt_r    <= 3'd0;
        end else if (step_s) begin
            acc_r    <= acc_shift_s;
            mplier_r <= mplier_shift_s;
            cnt_r    <= cnt_r + 3'd1;
            if (last_s) begin
                producto_r <= {acc_shift_s, mplier_shift_s};
            end
        end
    end

    // Status flags registered from the next state so they track state_r
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            listo_r   <= 1'b0;
            ocupado_r <= 1'b0;
        end else begin
            listo_r   <= (state_s == FIN);
            ocupado_r <= (state_s == CALCULO);
        end
    end

    assign producto = producto_r;
    assign listo    = listo_r;
    assign ocupado  = ocupado_r;

endmodule

// File: tb/tb_mult_secuencial_8b.sv
// ---------------------------------------------------------------------------
// tb_mult_secuencial_8b
// Scoreboard bench for mult_secuencial_8b. The driver pushes the expected
// product and the cycle at which listo must appear; the monitor pops and
// compares each time listo is seen.
// ---------------------------------------------------------------------------

module tb_mult_secuencial_8b;

    logic        clk;
    logic        rst_n;
    logic        inicio;
    logic [7:0]  a_in;
    logic [7:0]  b_in;
    logic [15:0] producto;
    logic        listo;
    logic        ocupado;

    typedef struct {
        logic [15:0] prod;
        int          cyc;
    } exp_t;

    exp_t        sb_q[$];
    int          cyc;
    int          checks;
    int          passes;
    int          listo_seen;
    logic [15:0] last_prod;

    mult_secuencial_8b dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .inicio   (inicio),
        .a        (a_in),
        .b        (b_in),
        .producto (producto),
        .listo    (listo),
        .ocupado  (ocupado)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act === exp) begin
            passes = passes + 1;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every listo pulse must match the oldest outstanding entry
    always @(negedge clk) begin
        if (listo === 1'b1) begin
            exp_t e;
            listo_seen = listo_seen + 1;
            if (sb_q.size() == 0) begin
                checks = checks + 1;
                $display("FAIL unexpected_listo: got listo=1, expected none (cycle %0d)", cyc);
            end else begin
                e = sb_q.pop_front();
                chk("producto", {16'd0, producto}, {16'd0, e.prod});
                chk("listo_cycle", cyc, e.cyc);
            end
        end else if (sb_q.size() > 0 && cyc > sb_q[0].cyc) begin
            exp_t e;
            e = sb_q.pop_front();
            checks = checks + 1;
            $display("FAIL listo_missing: got no listo, expected at cycle %0d (now %0d)", e.cyc, cyc);
        end
    end

    // Called at a negedge; leaves inicio low one negedge later.
    task automatic start(input logic [7:0] x, input logic [7:0] y, input bit push);
        exp_t e;
        a_in   = x;
        b_in   = y;
        inicio = 1'b1;
        if (push) begin
            e.prod = 16'(x) * 16'(y);
            e.cyc  = cyc + 9;
            sb_q.push_back(e);
        end
        @(negedge clk);
        inicio = 1'b0;
    endtask

    // Single operation with ocupado / producto-hold checks; exp is hand-computed
    task automatic run_directed(input logic [7:0] x, input logic [7:0] y, input logic [15:0] exp);
        exp_t e;
        a_in   = x;
        b_in   = y;
        inicio = 1'b1;
        e.prod = exp;
        e.cyc  = cyc + 9;
        sb_q.push_back(e);
        @(negedge clk);
        inicio = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk("ocupado_busy", {31'd0, ocupado}, 32'd1);
            chk("producto_hold", {16'd0, producto}, {16'd0, last_prod});
            @(negedge clk);
        end
        chk("ocupado_fin", {31'd0, ocupado}, 32'd0);
        last_prod = exp;
        @(negedge clk);
    endtask

    initial begin
        int base;
        cyc        = 0;
        checks     = 0;
        passes     = 0;
        listo_seen = 0;
        last_prod  = 16'h0000;
        rst_n      = 1'b0;
        inicio     = 1'b0;
        a_in       = 8'h00;
        b_in       = 8'h00;

        repeat (3) @(negedge clk);
        chk("rst_producto", {16'd0, producto}, 32'h0000);
        chk("rst_listo", {31'd0, listo}, 32'd0);
        chk("rst_ocupado", {31'd0, ocupado}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed products
        run_directed(8'h0D, 8'h0B, 16'h008F);
        run_directed(8'hFF, 8'hFF, 16'hFE01);
        run_directed(8'h00, 8'hA5, 16'h0000);
        run_directed(8'h01, 8'hFF, 16'h00FF);
        run_directed(8'h80, 8'h80, 16'h4000);

        // Inputs ignored while busy
        base = listo_seen;
        start(8'h0D, 8'h0B, 1'b1);
        @(negedge clk);
        a_in   = 8'h01;
        b_in   = 8'h01;
        inicio = 1'b1;
        @(negedge clk);
        inicio = 1'b0;
        repeat (10) @(negedge clk);
        chk("busy_one_listo", listo_seen - base, 32'd1);
        chk("busy_result", {16'd0, producto}, 32'h008F);

        // inicio held high: listo every 9 cycles, ocupado low only then
        a_in   = 8'h10;
        b_in   = 8'h10;
        inicio = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            exp_t e;
            e.prod = 16'h0100;
            e.cyc  = cyc + 9 * k;
            sb_q.push_back(e);
        end
        for (int n = 1; n <= 27; n++) begin
            @(negedge clk);
            chk("held_ocupado", {31'd0, ocupado}, (n % 9 == 0) ? 32'd0 : 32'd1);
            if (n == 27) inicio = 1'b0;
        end
        @(negedge clk);
        chk("held_idle", {31'd0, ocupado}, 32'd0);

        // Reset at iteration 4 aborts the operation
        base = listo_seen;
        start(8'hFF, 8'h02, 1'b0);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_producto", {16'd0, producto}, 32'h0000);
        chk("abort_ocupado", {31'd0, ocupado}, 32'd0);
        chk("abort_listo", {31'd0, listo}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        chk("abort_no_listo", listo_seen - base, 32'd0);
        chk("abort_idle", {31'd0, ocupado}, 32'd0);
        last_prod = 16'h0000;
        run_directed(8'h03, 8'h05, 16'h000F);

        // Random operand pairs, back-to-back starts
        for (int r = 0; r < 1000; r++) begin
            logic [7:0] x;
            logic [7:0] y;
            x = 8'($urandom_range(0, 255));
            y = 8'($urandom_range(0, 255));
            start(x, y, 1'b1);
            repeat (8) @(negedge clk);
        end

        // Drain with a bounded wait
        for (int t = 0; t < 40 && sb_q.size() > 0; t++) @(negedge clk);
        chk("queue_drained", sb_q.size(), 32'd0);
        repeat (2) @(negedge clk);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
